usb_cdc_in_arbiter: RTL and testbench
=====================================

# usb_cdc_in_arbiter

Round-robin arbiter that lets several 32-bit word producers share the single USB CDC IN (device-to-host) byte stream. Producers include the configuration-done acknowledger, a status reporter and user-fabric mailboxes. Each granted word is serialized big-endian as four bytes on a valid/ready byte interface that feeds the CDC IN endpoint. Words are atomic: bytes from different producers never interleave.

## Interface
- NUM_REQ, default 2: number of requesters; legal range 2..4.
- clk_i  input  1  system clock; all logic on its rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  NUM_REQ  per-requester word valid; bit k belongs to requester k.
- req_data_i  input  32*NUM_REQ  per-requester word; requester k is at bits [32k+31:32k].
- req_ready_o  output  NUM_REQ  per-requester word accept; a word is consumed when valid and ready are both high on a rising edge.
- in_data_o  output  8  byte to the CDC IN endpoint.
- in_valid_o  output  1  byte valid.
- in_ready_i  input  1  endpoint accepts in_data_o on a rising edge when in_valid_o is also high.
- grant_o  output  NUM_REQ  one-hot owner of the word currently being sent; all zero when idle.
- busy_o  output  1  high while a word is being serialized.

## Operation
- State machine with two states:
  - IDLE: no word is in flight.
  - SEND: a captured word is being serialized.
- IDLE behaviour:
  - The winner is the first k with req_valid_i[k]=1, searching upward from last_grant+1 modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge:
    - shift_reg <= winner's word.
    - byte_cnt <= 0.
    - last_grant <= winner.
    - grant_o <= one-hot(winner).
    - State goes to SEND.
  - With no valid request, stay in IDLE; all req_ready_o bits are 0.
- SEND behaviour:
  - in_valid_o=1 and in_data_o=shift_reg[31:24].
  - req_ready_o is all 0.
  - On an edge with in_ready_i=1:
    - shift_reg shifts left by 8, zero-filled.
    - byte_cnt increments; it is a 2-bit counter.
  - When the byte with byte_cnt=3 is accepted, go to IDLE and set grant_o to 0.
- in_valid_o and in_data_o are derived only from registered state, with no combinational path from in_ready_i.
- While in_ready_i=0, in_data_o and in_valid_o hold steady. This is the CDC stability rule.
- A requester may drop req_valid_i before it is granted. Nothing is consumed and it loses no fairness state.
- Only req_ready_o depends combinationally on req_valid_i. No output depends combinationally on req_data_i.

## Timing
- Reset values:
  - State is IDLE.
  - in_valid_o=0, in_data_o=0x00.
  - req_ready_o=0, grant_o=0, busy_o=0.
  - shift_reg=0, byte_cnt=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Latency: if the grant occurs in cycle T, byte 3 (MSB) is valid in T+1.
- With in_ready_i held high, bytes appear in T+1..T+4 and IDLE is in T+5.
- Throughput: minimum 5 cycles per word, because of one mandatory IDLE cycle between words.
- Back-pressure stretches SEND indefinitely. There is no timeout.
- busy_o equals (state==SEND). grant_o is registered and valid for exactly the SEND cycles.
- Simultaneous requests are resolved strictly round-robin. With N requesters continuously valid, each is served once every N words.
- Reset asserted mid-word:
  - All outputs immediately go to their reset values.
  - The partial word is dropped. Its remaining bytes are never sent and it is not retried.
  - The producer has already seen its handshake and must not resend.
- A req_valid_i change during SEND is ignored until the next IDLE cycle.

## Test plan
- Single word, NUM_REQ=2: req0 presents 0xFAB0_FABF with in_ready_i=1 → req_ready_o=01 for one cycle, then in_data_o = FA, B0, FA, BF on 4 consecutive valid cycles; grant_o=01 and busy_o=1 for exactly those 4 cycles, then IDLE.
- Contention: after reset, req0=0x11223344 and req1=0xAABBCCDD are both held valid → output 11 22 33 44, then AA BB CC DD, then req0's next word. The same valid pair is never granted twice in a row.
- Back-pressure: during req1's word, in_ready_i=0 for 3 cycles while byte 0xBB is presented → in_data_o stays 0xBB and in_valid_o stays 1 for all 3 cycles; the full sequence AA BB CC DD is emitted with no drop or duplicate.
- Round-robin wrap, NUM_REQ=3: with last_grant=1, req0 and req2 become valid simultaneously → req2 is granted first, then req0.
- Reset mid-word: assert reset_n_i low after 2 bytes of 0x01020304 → in_valid_o=0 immediately. After release, with no requests, no bytes are emitted; a new req1 word 0x55667788 is sent complete.
- Withdrawn request: req1 pulses valid for 1 cycle while the arbiter is in SEND for req0 → req1 is never acknowledged and its word is never emitted; the next grant still follows round-robin.

Source files
------------

// File: rtl/usb_cdc_in_arbiter.sv
// Round-robin arbiter that merges several 32-bit word producers onto the CDC IN byte stream.
// Each granted word is sent whole, MSB first. Bytes from different producers never interleave.
module usb_cdc_in_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [32*NUM_REQ-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             in_data_o,
    output logic                   in_valid_o,
    input  logic                   in_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        shift_q, shift_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [31:0]        win_data;

    // Search upward from the requester after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int idx;
            idx = (int'(last_grant_q) + off) % NUM_REQ;
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_onehot[k] = 1'b1;
                win_data      = req_data_i[32*k +: 32];
            end
        end
    end

    // State register together with the datapath registers it sequences.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the pre-edge value of the others.
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    // Next-state logic: capture on grant, shift out one byte per accepted beat.
    always_comb begin
        // NOTE: hold-value defaults on every path keep this block free of inferred latches.
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    shift_d      = win_data;
                    byte_cnt_d   = 2'd0;
                    last_grant_d = win_idx;
                    grant_d      = win_onehot;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (in_ready_i) begin
                    shift_d    = {shift_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte-side outputs come only from registers, so they stay steady under back-pressure.
    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && win_found) begin
            req_ready_o = win_onehot;
        end
        in_valid_o = (state_q == SEND);
        in_data_o  = shift_q[31:24];
        grant_o    = grant_q;
        busy_o     = (state_q == SEND);
    end

endmodule

// File: tb/tb_usb_cdc_in_arbiter.sv
// Self-checking bench for usb_cdc_in_arbiter: a cycle table, a byte scoreboard for streamed words,
// and a NUM_REQ=3 instance for round-robin wrap.
module tb_usb_cdc_in_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready = 1'b0;
    logic [1:0]  grant;
    logic        busy;

    logic [2:0]  req_valid3 = '0;
    logic [95:0] req_data3 = '0;
    logic [2:0]  req_ready3;
    logic [7:0]  in_data3;
    logic        in_valid3;
    logic        in_ready3 = 1'b1;
    logic [2:0]  grant3;
    logic        busy3;

    usb_cdc_in_arbiter #(.NUM_REQ(2)) u_dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    usb_cdc_in_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .req_valid_i (req_valid3),
        .req_data_i  (req_data3),
        .req_ready_o (req_ready3),
        .in_data_o   (in_data3),
        .in_valid_o  (in_valid3),
        .in_ready_i  (in_ready3),
        .grant_o     (grant3),
        .busy_o      (busy3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] p0_q[$];
    logic [31:0] p1_q[$];
    logic        mon_en = 1'b0;
    logic [1:0]  prev_win = '0;
    int          bp_cnt = 0;
    logic        bp_arm = 1'b0;
    int          stall_seen = 0;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] d0;
        logic        ir;
        logic [1:0]  e_rdy;
        logic        e_val;
        logic [7:0]  e_data;
        logic [1:0]  e_gnt;
        logic        e_busy;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic void push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endfunction

    // Scoreboard: every accepted byte must be the next expected one.
    always @(negedge clk) begin
        if (mon_en && rst_n && in_valid && in_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no byte", in_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("stream_byte", {24'd0, in_data}, {24'd0, e});
            end
        end
    end

    task automatic drive_producers();
        req_valid[0]     = (p0_q.size() > 0);
        req_valid[1]     = (p1_q.size() > 0);
        req_data[31:0]   = (p0_q.size() > 0) ? p0_q[0] : 32'h0;
        req_data[63:32]  = (p1_q.size() > 0) ? p1_q[0] : 32'h0;
    endtask

    // One clock: sample at negedge, consume handshakes, drive new inputs just after posedge.
    task automatic run_cycle();
        logic [1:0] hs;
        @(negedge clk);
        #1;
        hs = req_ready & req_valid;
        if (req_valid == 2'b11 && hs != 2'b00 && prev_win != 2'b00)
            check("rr_alternate", {30'd0, hs}, {30'd0, ~prev_win});
        if (hs != 2'b00) prev_win = hs;
        if (hs[0]) p0_q.delete(0);
        if (hs[1]) p1_q.delete(0);
        if (!in_ready) begin
            stall_seen++;
            check("bp_valid_hold", {31'd0, in_valid}, 32'd1);
            check("bp_data_hold", {24'd0, in_data}, 32'h0000_00BB);
        end
        if (bp_arm && in_valid && in_ready && in_data == 8'hAA) begin
            bp_cnt = 3;
            bp_arm = 1'b0;
        end
        @(posedge clk);
        #1;
        in_ready = (bp_cnt == 0);
        if (bp_cnt > 0) bp_cnt--;
        drive_producers();
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (n < max_cycles && !(exp_q.size() == 0 && p0_q.size() == 0 &&
                                   p1_q.size() == 0 && !busy)) begin
            run_cycle();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 32'd0);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        req_valid  = '0;
        req_data   = '0;
        req_valid3 = '0;
        rst_n      = 1'b0;
        prev_win   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 32'hFAB0_FABF, 1'b1, 2'b01, 1'b0, 8'h00, 2'b00, 1'b0};
        tbl[1] = '{2'b00, 32'h0,         1'b1, 2'b00, 1'b1, 8'hFA, 2'b01, 1'b1};
        tbl[2] = '{2'b00, 32'h0,         1'b1, 2'b00, 1'b1, 8'hB0, 2'b01, 1'b1};
        tbl[3] = '{2'b00, 32'h0,         1'b1, 2'b00, 1'b1, 8'hFA, 2'b01, 1'b1};
        tbl[4] = '{2'b00, 32'h0,         1'b1, 2'b00, 1'b1, 8'hBF, 2'b01, 1'b1};
        tbl[5] = '{2'b00, 32'h0,         1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
        tbl[6] = '{2'b00, 32'h0,         1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};

        // Reset values while reset is held and just after release.
        #1;
        check("rst_valid", {31'd0, in_valid}, 32'd0);
        check("rst_data", {24'd0, in_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {30'd0, req_ready}, 32'd0);
        check("post_rst_grant3", {29'd0, grant3}, 32'd0);
        @(posedge clk);
        #1;

        // Single word, cycle by cycle.
        for (int i = 0; i < 7; i++) begin
            req_valid = tbl[i].rv;
            req_data  = {32'h0, tbl[i].d0};
            in_ready  = tbl[i].ir;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), {30'd0, req_ready}, {30'd0, tbl[i].e_rdy});
            check($sformatf("tbl%0d_valid", i), {31'd0, in_valid}, {31'd0, tbl[i].e_val});
            check($sformatf("tbl%0d_data", i), {24'd0, in_data}, {24'd0, tbl[i].e_data});
            check($sformatf("tbl%0d_grant", i), {30'd0, grant}, {30'd0, tbl[i].e_gnt});
            check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            @(posedge clk);
            #1;
        end

        // Contention with back-pressure on byte 0xBB.
        do_reset();
        p0_q.push_back(32'h1122_3344);
        p0_q.push_back(32'h0A0B_0C0D);
        p1_q.push_back(32'hAABB_CCDD);
        push_word(32'h1122_3344);
        push_word(32'hAABB_CCDD);
        push_word(32'h0A0B_0C0D);
        bp_arm     = 1'b1;
        stall_seen = 0;
        mon_en     = 1'b1;
        in_ready   = 1'b1;
        drive_producers();
        wait_drain("contention", 60);
        check("bp_stall_cycles", stall_seen, 32'd3);

        // Reset in the middle of a word.
        do_reset();
        p0_q.push_back(32'h0102_0304);
        push_word(32'h0102_0304);
        in_ready = 1'b1;
        drive_producers();
        for (int n = 0; n < 20 && exp_q.size() > 2; n++) run_cycle();
        in_ready = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, in_valid}, 32'd0);
        check("midrst_data", {24'd0, in_data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_grant", {30'd0, grant}, 32'd0);
        check("midrst_bytes_left", exp_q.size(), 32'd2);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_ready = 1'b1;
        drive_producers();
        repeat (8) run_cycle();
        p1_q.push_back(32'h5566_7788);
        push_word(32'h5566_7788);
        drive_producers();
        wait_drain("after_reset", 30);

        // Withdrawn request during SEND, then round-robin continues from req0's grant.
        p0_q.push_back(32'hC0C1_C2C3);
        push_word(32'hC0C1_C2C3);
        drive_producers();
        run_cycle();
        run_cycle();
        p1_q.push_back(32'hEEEE_EEEE);
        drive_producers();
        @(negedge clk);
        #1;
        check("withdrawn_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        p1_q.delete();
        drive_producers();
        p0_q.push_back(32'hD0D1_D2D3);
        p1_q.push_back(32'h99AA_BBCC);
        push_word(32'h99AA_BBCC);
        push_word(32'hD0D1_D2D3);
        drive_producers();
        wait_drain("withdrawn", 60);
        mon_en = 1'b0;

        // Round-robin wrap with three requesters.
        req_data3  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        in_ready3  = 1'b1;
        req_valid3 = 3'b010;
        @(negedge clk);
        check("rr3_first_ready", {29'd0, req_ready3}, 32'h2);
        @(posedge clk);
        #1;
        req_valid3 = 3'b000;
        @(negedge clk);
        check("rr3_first_grant", {29'd0, grant3}, 32'h2);
        check("rr3_first_busy", {31'd0, busy3}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        req_valid3 = 3'b101;
        @(negedge clk);
        check("rr3_idle_busy", {31'd0, busy3}, 32'd0);
        check("rr3_wrap_ready", {29'd0, req_ready3}, 32'h4);
        @(posedge clk);
        #1;
        req_valid3 = 3'b001;
        @(negedge clk);
        check("rr3_wrap_grant", {29'd0, grant3}, 32'h4);
        check("rr3_wrap_msb", {24'd0, in_data3}, 32'h33);
        check("rr3_send_ready", {29'd0, req_ready3}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("rr3_next_ready", {29'd0, req_ready3}, 32'h1);
        @(posedge clk);
        #1;
        req_valid3 = 3'b000;
        repeat (5) @(posedge clk);
        #1;
        check("rr3_end_busy", {31'd0, busy3}, 32'd0);
        check("rr3_end_grant", {29'd0, grant3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
